// File: rtl/mq_fifo_pkg.sv
// Shared definitions for the multi-queue FIFO: default sizing, threshold
// defaults and the width rules used to derive dependent parameters.
package mq_fifo_pkg;

  localparam int DEF_NUM_QUEUES    = 32'd4;
  localparam int DEF_ADDR_WIDTH    = 32'd9;
  localparam int DEF_DATA_WIDTH    = 32'd16;
  localparam int DEF_AEMPTY_THRESH = 32'd2;

  // Queue-ID width for a power-of-two queue count (>= 2).
  function automatic int qid_width(input int num_queues);
    return $clog2(num_queues);
  endfunction

  // Count width must be able to hold the full depth 2^addr_width.
  function automatic int count_width(input int addr_width);
    return addr_width + 32'd1;
  endfunction

  // Default almost-full level: two entries short of the per-queue depth.
  function automatic int afull_thresh(input int addr_width);
    return (32'd1 << addr_width) - 32'd2;
  endfunction

endpackage

// File: rtl/mq_fifo_ram.sv
// Simple dual-port, single-clock RAM with a registered read port.
// Storage is not reset; only the output register is.
module mq_fifo_ram
  import mq_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH + 32'd2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port: store the entry on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed entry, hold it between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mq_sync_fifo.sv
// Multi-queue synchronous FIFO: NUM_QUEUES logical queues statically
// partitioned in one shared RAM (address = {qid, ptr}), with per-queue
// pointers, counts and status flags, and a tagged registered read port.
module mq_sync_fifo
  import mq_fifo_pkg::*;
#(
  parameter int NUM_QUEUES    = DEF_NUM_QUEUES,
  parameter int QID_WIDTH     = qid_width(NUM_QUEUES),
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH   = count_width(ADDR_WIDTH),
  parameter int AFULL_THRESH  = afull_thresh(ADDR_WIDTH),
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [QID_WIDTH-1:0]              wr_qid,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_en,
  input  logic [QID_WIDTH-1:0]              rd_qid,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic [QID_WIDTH-1:0]              rd_qid_out,
  output logic [NUM_QUEUES-1:0]             full,
  output logic [NUM_QUEUES-1:0]             empty,
  output logic [NUM_QUEUES-1:0]             almost_full,
  output logic [NUM_QUEUES-1:0]             almost_empty,
  output logic                              wr_err,
  output logic                              rd_err,
  output logic [NUM_QUEUES*COUNT_WIDTH-1:0] data_count,
  output logic [QID_WIDTH+COUNT_WIDTH-1:0]  total_count
);

  localparam int RAM_AW = QID_WIDTH + ADDR_WIDTH;
  localparam int TOT_W  = QID_WIDTH + COUNT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT  = COUNT_WIDTH'(32'd1 << ADDR_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] AFULL_LVL  = COUNT_WIDTH'(AFULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_LVL = COUNT_WIDTH'(AEMPTY_THRESH);
  localparam logic [NUM_QUEUES-1:0]  ONE_HOT0   = {{(NUM_QUEUES-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0]  wptr_r  [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0]  rptr_r  [NUM_QUEUES];
  logic [COUNT_WIDTH-1:0] count_r [NUM_QUEUES];
  logic [TOT_W-1:0]       total_r;
  logic                   rd_valid_r;
  logic [QID_WIDTH-1:0]   rd_qid_r;

  logic [NUM_QUEUES-1:0]  full_s;
  logic [NUM_QUEUES-1:0]  empty_s;
  logic [NUM_QUEUES-1:0]  afull_s;
  logic [NUM_QUEUES-1:0]  aempty_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic [NUM_QUEUES-1:0]  wr_sel_s;
  logic [NUM_QUEUES-1:0]  rd_sel_s;
  logic [RAM_AW-1:0]      wr_addr_s;
  logic [RAM_AW-1:0]      rd_addr_s;

  // Per-queue flags straight from the registered counts, plus count export.
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    assign full_s[q]   = (count_r[q] == MAX_COUNT);
    assign empty_s[q]  = (count_r[q] == {COUNT_WIDTH{1'b0}});
    assign afull_s[q]  = (count_r[q] >= AFULL_LVL);
    assign aempty_s[q] = (count_r[q] <= AEMPTY_LVL);
    assign data_count[q*COUNT_WIDTH +: COUNT_WIDTH] = count_r[q];
  end

  // Acceptance uses pre-update flags, so a same-queue read/write pair can
  // never hit the same RAM address in one cycle.
  assign wr_acc_s  = wr_en & ~full_s[wr_qid];
  assign rd_acc_s  = rd_en & ~empty_s[rd_qid];
  assign wr_sel_s  = wr_acc_s ? (ONE_HOT0 << wr_qid) : {NUM_QUEUES{1'b0}};
  assign rd_sel_s  = rd_acc_s ? (ONE_HOT0 << rd_qid) : {NUM_QUEUES{1'b0}};
  assign wr_addr_s = {wr_qid, wptr_r[wr_qid]};
  assign rd_addr_s = {rd_qid, rptr_r[rd_qid]};

  assign wr_err = wr_en & full_s[wr_qid];
  assign rd_err = rd_en & empty_s[rd_qid];

  // Per-queue pointer and occupancy update; counts move by +1/-1/0 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wptr_r[q]  <= '0;
        rptr_r[q]  <= '0;
        count_r[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (wr_sel_s[q]) begin
          wptr_r[q] <= wptr_r[q] + 1'b1;
        end
        if (rd_sel_s[q]) begin
          rptr_r[q] <= rptr_r[q] + 1'b1;
        end
        case ({wr_sel_s[q], rd_sel_s[q]})
          2'b10:   count_r[q] <= count_r[q] + 1'b1;
          2'b01:   count_r[q] <= count_r[q] - 1'b1;
          default: count_r[q] <= count_r[q];
        endcase
      end
    end
  end

  // Aggregate occupancy across all queues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_r <= '0;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   total_r <= total_r + 1'b1;
        2'b01:   total_r <= total_r - 1'b1;
        default: total_r <= total_r;
      endcase
    end
  end

  // Read tag: valid for exactly the cycle after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_qid_r   <= '0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_qid_r <= rd_qid;
      end
    end
  end

  mq_fifo_ram #(
    .ADDR_WIDTH (RAM_AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc_s),
    .waddr (wr_addr_s),
    .wdata (wr_data),
    .re    (rd_acc_s),
    .raddr (rd_addr_s),
    .rdata (rd_data)
  );

  assign rd_valid     = rd_valid_r;
  assign rd_qid_out   = rd_qid_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = afull_s;
  assign almost_empty = aempty_s;
  assign total_count  = total_r;

endmodule

// File: doc/mq_sync_fifo.md
Name: mq_sync_fifo

Overview:
- Multi-queue synchronous FIFO: NUM_QUEUES logical queues statically partitioned in one shared simple-dual-port RAM, one write port and one read port, each steered by a queue ID.
- Per-queue pointers, occupancy counts, full/empty and almost-full/almost-empty flags.
- Registered read data with a valid/qid tag.
- Sits in the switch queueing stage as the per-output/per-priority packet-descriptor store ahead of the EDF scheduler.

Parameters:
- NUM_QUEUES, 4, number of logical queues; power of two, >=2
- QID_WIDTH, $clog2(NUM_QUEUES), queue ID width; derived, not overridden
- ADDR_WIDTH, 9, per-queue address width; depth per queue = 2^ADDR_WIDTH
- DATA_WIDTH, 16, entry width
- COUNT_WIDTH, ADDR_WIDTH+1, per-queue count width; must hold the value 2^ADDR_WIDTH
- AFULL_THRESH, (1<<ADDR_WIDTH)-2, almost_full asserts when count >= this value
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_qid  in  QID_WIDTH  target queue of write
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_qid  in  QID_WIDTH  source queue of read
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  rd_data valid this cycle
- rd_qid_out  out  QID_WIDTH  queue that rd_data came from
- full  out  NUM_QUEUES  per-queue full (count == 2^ADDR_WIDTH)
- empty  out  NUM_QUEUES  per-queue empty (count == 0)
- almost_full  out  NUM_QUEUES  per-queue count >= AFULL_THRESH
- almost_empty  out  NUM_QUEUES  per-queue count <= AEMPTY_THRESH
- wr_err  out  1  wr_en while full[wr_qid]; combinational
- rd_err  out  1  rd_en while empty[rd_qid]; combinational
- data_count  out  NUM_QUEUES*COUNT_WIDTH  per-queue counts; queue q at bits [q*COUNT_WIDTH +: COUNT_WIDTH]
- total_count  out  QID_WIDTH+COUNT_WIDTH  sum of all queue counts, registered

Behaviour:
- Single clock clk. rst_n is asynchronous, active-low.
- Reset state:
  - All pointers and counts = 0; total_count = 0.
  - empty = all 1s; full = 0.
  - almost_empty = all 1s; almost_full = 0.
  - rd_valid = 0; rd_data = 0; rd_qid_out = 0.
  - RAM contents are not reset.
- Reset mid-operation: all state returns to the reset values immediately; in-flight reads are dropped (rd_valid = 0).
- Write acceptance: wr_acc = wr_en & ~full[wr_qid].
  - When accepted: RAM[{wr_qid, wptr[wr_qid]}] <= wr_data; wptr[wr_qid] += 1, wrapping modulo 2^ADDR_WIDTH.
  - When rejected: no state change.
- Read acceptance: rd_acc = rd_en & ~empty[rd_qid].
  - When accepted: rptr[rd_qid] += 1 (wraps).
  - Next cycle: rd_valid = 1, rd_data = entry at the old rptr, rd_qid_out = rd_qid.
  - rd_valid = 0 on every other cycle. rd_data holds its last value when rd_valid = 0.
- Read latency: 1 cycle from rd_acc to rd_valid.
- Flags use the current (pre-update) count.
  - A write to an empty queue is readable no earlier than the next cycle: write at cycle N, read accepted at N+1, data at N+2.
- Simultaneous read and write, different queues: each updates independently.
- Simultaneous read and write, same queue q:
  - 0 < count < max: both accepted, count unchanged.
  - count == 0: write accepted, read rejected with rd_err = 1; count becomes 1.
  - count == max: read accepted, write rejected with wr_err = 1; count becomes max-1.
- Count update per queue: count += (wr_acc to q) - (rd_acc from q). Never wraps.
- total_count is updated the same way from the wr_acc/rd_acc totals.
- All flags are combinational from the registered counts.
- RAM: depth NUM_QUEUES*2^ADDR_WIDTH, address = {qid, ptr}, synchronous read, registered output.
  - Read and write to the same address in one cycle cannot occur (guaranteed by the flag rules above), so no bypass logic is required.

Decomposition:
- Shared package mq_fifo_pkg holds:
  - queue-ID width function
  - count-width rule (ADDR_WIDTH+1)
  - default threshold constants
- One natural sub-module: mq_fifo_ram, a simple dual-port, single-clock RAM with registered read (depth 2^(QID_WIDTH+ADDR_WIDTH)).
- Pointers, counts and flags stay in the top level, generated per queue.

Test Plan:
Configuration: NUM_QUEUES=4, ADDR_WIDTH=3 (depth 8), AFULL_THRESH=6, AEMPTY_THRESH=2.
1. Write 0x11,0x22,0x33 to q2, then read q2 three times -> rd_data 0x11,0x22,0x33, each 1 cycle after its read with rd_qid_out = 2. Then empty[2] = 1 and data_count q2 = 0.
2. Fill q1 with 8 writes, then a 9th write -> full[1] = 1 after the 8th write; almost_full[1] = 1 from count 6; 9th write gives wr_err = 1 and count stays 8. Reading all 8 returns data in order.
3. Read q3 while empty, with a simultaneous write 0xAB to q3 -> rd_err = 1, no rd_valid, count q3 = 1. A read on the next cycle returns 0xAB.
4. q0 full (8 entries) plus a simultaneous read q0 and write q0 -> read accepted, write rejected with wr_err = 1, count = 7. Interleave writes to q0 and reads from q1 over 20 cycles -> per-queue order preserved, no cross-queue corruption, total_count matches a scoreboard.
5. Pointer wrap: 20 write/read pairs on q2 at count 3 -> data in order across the pointer wrap, count stays 3.
6. Assert rst_n low mid-stream with q0=5 and q1=2 entries and a read in flight -> rd_valid = 0 immediately, all counts 0, empty = 4'b1111. Writes after reset return fresh data.
